// File: rtl/rfphoenix_icache_refill.sv
// rfPhoenix instruction-cache miss handler: tag compare, 4-beat line refill, tag/data write.
// Define RFPHOENIX_ICACHE_LFSR_EN to choose victims from a 16-bit LFSR instead of round-robin.
module rfphoenix_icache_refill #(
    parameter int LINES = 128,
    parameter int WAYS  = 4,
    parameter int AWID  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AWID-1:0]            ip,
    input  logic                       ip_v,
    input  logic [WAYS-1:0][AWID-1:6]  tag,
    output logic                       hit,
    output logic [1:0]                 hit_way,
    output logic                       stall,
    output logic                       mem_req,
    output logic [AWID-1:0]            mem_adr,
    input  logic                       mem_ack,
    input  logic [127:0]               mem_dat,
    output logic                       wr,
    output logic [AWID-1:0]            ipo,
    output logic [1:0]                 way,
    output logic [511:0]               line
);

    localparam int IDX_LSB = 6;
    localparam int IDX_MSB = IDX_LSB + $clog2(LINES) - 1;

    typedef enum logic [2:0] {IDLE, REQ, FILL, WRITE, SETTLE} state_t;

    state_t            state_reg, state_next;
    logic [AWID-1:0]   rip_reg, rip_next;
    logic              rip_v_reg, rip_v_next;
    logic [AWID-1:0]   miss_reg, miss_next;
    logic [1:0]        vway_reg, vway_next;
    logic [1:0]        beat_reg, beat_next;
    logic              mem_req_reg, mem_req_next;
    logic [AWID-1:0]   mem_adr_reg, mem_adr_next;
    logic              wr_reg, wr_next;
    logic [AWID-1:0]   ipo_reg, ipo_next;
    logic [1:0]        way_reg, way_next;
    logic [511:0]      line_reg, line_next;
    logic [WAYS-1:0]   match;
    logic [1:0]        victim_sel;
    logic              ack_ok;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
            assign match[gi] = (tag[gi] == rip_reg[AWID-1:6]);
        end
    endgenerate

    // Beats only count while a refill is outstanding; stray acks elsewhere are dropped.
    assign ack_ok = mem_ack && (state_reg == REQ || state_reg == FILL);

`ifdef RFPHOENIX_ICACHE_LFSR_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (!rst_n)
            lfsr_reg <= 16'hACE1;
        else
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end

    assign victim_sel = lfsr_reg[1:0];
`else
    logic [1:0] rr_reg;

    always_ff @(posedge clk) begin
        if (!rst_n)
            rr_reg <= 2'd0;
        else if (state_reg == WRITE)
            rr_reg <= (rr_reg == 2'(WAYS - 1)) ? 2'd0 : rr_reg + 2'd1;
    end

    assign victim_sel = rr_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (rip_v_reg && !hit) state_next = REQ;
            REQ:     if (mem_ack) state_next = FILL;
            FILL:    if (mem_ack && beat_reg == 2'd3) state_next = WRITE;
            WRITE:   state_next = SETTLE;
            SETTLE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hit     = rip_v_reg && (|match);
        hit_way = 2'd0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (match[w]) hit_way = 2'(w);
        stall   = (state_reg == IDLE) ? (rip_v_reg && !hit) : 1'b1;

        rip_next     = rip_reg;
        rip_v_next   = rip_v_reg;
        miss_next    = miss_reg;
        vway_next    = vway_reg;
        beat_next    = beat_reg;
        mem_req_next = mem_req_reg;
        mem_adr_next = mem_adr_reg;
        wr_next      = 1'b0;
        ipo_next     = ipo_reg;
        way_next     = way_reg;
        line_next    = line_reg;

        if (state_reg == IDLE) begin
            rip_next   = ip;
            rip_v_next = ip_v;
        end
        if (state_reg == IDLE && state_next == REQ) begin
            miss_next    = rip_reg;
            vway_next    = victim_sel;
            mem_req_next = 1'b1;
            mem_adr_next = {rip_reg[AWID-1:6], 6'b0};
        end
        if (ack_ok) begin
            beat_next = beat_reg + 2'd1;
            line_next[{beat_reg, 7'b0} +: 128] = mem_dat;
        end
        // Tag write address keeps tag, set index and offset of the missing fetch.
        if (state_reg == FILL && state_next == WRITE) begin
            mem_req_next = 1'b0;
            wr_next      = 1'b1;
            ipo_next     = {miss_reg[AWID-1:IDX_MSB+1], miss_reg[IDX_MSB:IDX_LSB], miss_reg[IDX_LSB-1:0]};
            way_next     = vway_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rip_reg     <= '0;
            rip_v_reg   <= 1'b0;
            miss_reg    <= '0;
            vway_reg    <= 2'd0;
            beat_reg    <= 2'd0;
            mem_req_reg <= 1'b0;
            mem_adr_reg <= '0;
            wr_reg      <= 1'b0;
            ipo_reg     <= '0;
            way_reg     <= 2'd0;
            line_reg    <= '0;
        end else begin
            rip_reg     <= rip_next;
            rip_v_reg   <= rip_v_next;
            miss_reg    <= miss_next;
            vway_reg    <= vway_next;
            beat_reg    <= beat_next;
            mem_req_reg <= mem_req_next;
            mem_adr_reg <= mem_adr_next;
            wr_reg      <= wr_next;
            ipo_reg     <= ipo_next;
            way_reg     <= way_next;
            line_reg    <= line_next;
        end
    end

    assign mem_req = mem_req_reg;
    assign mem_adr = mem_adr_reg;
    assign wr      = wr_reg;
    assign ipo     = ipo_reg;
    assign way     = way_reg;
    assign line    = line_reg;

endmodule

// File: tb/tb_rfphoenix_icache_refill.sv
// Randomized scoreboard bench for rfphoenix_icache_refill: tag store, memory responder and
// a reference cache model; refill writes are checked by a monitor against queued expectations.
module tb_rfphoenix_icache_refill;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [31:0]        ip = '0;
    logic               ip_v = 1'b0;
    logic [3:0][31:6]   tag;
    logic               hit;
    logic [1:0]         hit_way;
    logic               stall;
    logic               mem_req;
    logic [31:0]        mem_adr;
    logic               mem_ack = 1'b0;
    logic [127:0]       mem_dat = '0;
    logic               wr;
    logic [31:0]        ipo;
    logic [1:0]         way;
    logic [511:0]       line;

    rfphoenix_icache_refill #(.LINES(128), .WAYS(4), .AWID(32)) dut (
        .clk(clk), .rst_n(rst_n), .ip(ip), .ip_v(ip_v), .tag(tag),
        .hit(hit), .hit_way(hit_way), .stall(stall),
        .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack), .mem_dat(mem_dat),
        .wr(wr), .ipo(ipo), .way(way), .line(line)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Environment tag store: registered read of the fetch address, written by the DUT strobe.
    bit [31:6]  tagmem [4][128];
    logic       pl_we = 1'b0;
    logic [1:0] pl_way = '0;
    logic [6:0] pl_idx = '0;
    logic [31:6] pl_tag = '0;

    always @(posedge clk) begin
        for (int w = 0; w < 4; w++) tag[w] <= tagmem[w][ip[12:6]];
        if (wr) tagmem[way][ipo[12:6]] <= ipo[31:6];
        if (pl_we) tagmem[pl_way][pl_idx] <= pl_tag;
    end

    // Reference model state
    bit [31:6]  ref_tags [4][128];
    int         rr_m = 0;
`ifdef RFPHOENIX_ICACHE_LFSR_EN
    bit [15:0]  lfsr_m;
    always @(posedge clk) begin
        if (!rst_n) lfsr_m <= 16'hACE1;
        else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
`endif

    typedef struct packed {
        logic [31:0]  adr;
        logic [1:0]   vway;
        logic [511:0] data;
    } refill_t;

    refill_t      refill_q[$];
    logic [31:0]  req_q[$];
    logic [127:0] beat_q[$];
    int           cnt_q[$];
    int           beats_given = 0;
    logic [31:0]  used[$];

    // Memory responder: random gaps between beats, spurious acks while no request is open.
    initial begin
        int n, gap;
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_dat = {$urandom, $urandom, $urandom, $urandom};
            if (rst_n && mem_req && !prev_req) begin
                chk("req_expected", cnt_q.size() != 0, 1'b1);
                if (cnt_q.size() != 0) begin
                    n = cnt_q.pop_front();
                    for (int k = 0; k < n; k++) begin
                        gap = $urandom_range(0, 2);
                        repeat (gap) @(negedge clk);
                        mem_ack = 1'b1;
                        mem_dat = beat_q.pop_front();
                        beats_given++;
                        @(negedge clk);
                        mem_ack = 1'b0;
                    end
                end
            end else if (!mem_req && $urandom_range(0, 5) == 0) begin
                mem_ack = 1'b1;
            end
            prev_req = mem_req;
        end
    end

    // Monitor: request address, stall during refill, and each tag/data write strobe.
    initial begin
        logic        prev_req, prev_wr;
        logic [31:0] cur_adr;
        refill_t     r;
        prev_req = 1'b0; prev_wr = 1'b0; cur_adr = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_req && !prev_req) begin
                    chk("mem_adr_expected", req_q.size() != 0, 1'b1);
                    if (req_q.size() != 0) cur_adr = req_q.pop_front();
                end
                if (mem_req) begin
                    chk("mem_adr", mem_adr, cur_adr);
                    chk("stall_in_refill", stall, 1'b1);
                end
                if (wr) begin
                    chk("wr_single_cycle", prev_wr, 1'b0);
                    chk("wr_expected", refill_q.size() != 0, 1'b1);
                    if (refill_q.size() != 0) begin
                        r = refill_q.pop_front();
                        chk("ipo", ipo, r.adr);
                        chk("way", way, r.vway);
                        chk("line", line, r.data);
                        $display("refill adr=%08h way=%0d", ipo, way);
                    end
                end
            end
            prev_req = mem_req;
            prev_wr  = wr;
        end
    end

    // mode 0: random beats, 1: beats 1..4, 2: reset after the second beat
    task automatic access(input logic [31:0] a, input int mode);
        logic [6:0]   idx;
        logic         exp_hit;
        logic [1:0]   exp_way, v;
        logic [127:0] b;
        logic [511:0] ln;
        int           n, nb, target;
        refill_t      r;
        @(negedge clk);
        ip = a; ip_v = 1'b1;
        @(negedge clk);
        idx = a[12:6]; exp_hit = 1'b0; exp_way = 2'd0;
        for (int w = 0; w < 4; w++)
            if (!exp_hit && ref_tags[w][idx] == a[31:6]) begin exp_hit = 1'b1; exp_way = 2'(w); end
        $display("access ip=%08h expect_hit=%0d", a, exp_hit);
        chk("hit", hit, exp_hit);
        chk("stall", stall, !exp_hit);
        if (exp_hit) begin
            chk("hit_way", hit_way, exp_way);
            chk("no_req_on_hit", mem_req, 1'b0);
        end else begin
`ifdef RFPHOENIX_ICACHE_LFSR_EN
            v = lfsr_m[1:0];
`else
            v = 2'(rr_m);
`endif
            req_q.push_back({a[31:6], 6'b0});
            nb = (mode == 2) ? 2 : 4;
            cnt_q.push_back(nb);
            ln = '0;
            for (int k = 0; k < nb; k++) begin
                b = (mode == 1) ? 128'(k + 1) : {$urandom, $urandom, $urandom, $urandom};
                beat_q.push_back(b);
                ln[128*k +: 128] = b;
            end
            if (mode == 2) begin
                target = beats_given + 2;
                n = 0;
                while (beats_given < target && n < 100) begin @(negedge clk); n++; end
                chk("abort_beats", beats_given, target);
                @(negedge clk);
                rst_n = 1'b0; ip_v = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                rr_m = 0;
                chk("abort_mem_req", mem_req, 1'b0);
                chk("abort_wr", wr, 1'b0);
                chk("abort_stall", stall, 1'b0);
                chk("abort_line", line, '0);
                chk("abort_way", way, 2'd0);
                repeat (12) @(negedge clk);
                chk("abort_idle_req", mem_req, 1'b0);
            end else begin
                r.adr = a; r.vway = v; r.data = ln;
                refill_q.push_back(r);
                ref_tags[v][idx] = a[31:6];
                rr_m = (rr_m + 1) % 4;
                n = 0;
                do begin @(negedge clk); n++; end while (stall && n < 200);
                chk("refill_done", stall, 1'b0);
                chk("hit_after_settle", hit, 1'b1);
                chk("hit_way_after_settle", hit_way, v);
                chk("mem_req_after", mem_req, 1'b0);
                chk("refill_seen", refill_q.size(), 0);
            end
        end
        used.push_back(a);
    endtask

    function automatic logic [31:0] rand_addr();
        return {19'($urandom_range(1, 511)), 7'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        repeat (3) @(negedge clk);
        a = 32'h1000;
        pl_we = 1'b1; pl_way = 2'd1; pl_idx = a[12:6]; pl_tag = a[31:6];
        ref_tags[1][a[12:6]] = a[31:6];
        @(negedge clk);
        pl_we = 1'b0;
        rst_n = 1'b1;
        chk("rst_hit", hit, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_adr", mem_adr, '0);
        chk("rst_wr", wr, 1'b0);
        chk("rst_ipo", ipo, '0);
        chk("rst_way", way, 2'd0);
        chk("rst_line", line, '0);

        access(32'h1000, 0);
        access(32'h2040, 1);
        access(32'h2040, 0);
        for (int i = 0; i < 5; i++) access(32'h0010_0000 + 32'(i) * 32'h0002_0000, 0);
        access(32'h0044_0080, 2);
        for (int i = 0; i < 5; i++) access(32'h0080_0000 + 32'(i) * 32'h0002_0000, 0);
        for (int i = 0; i < 40; i++) begin
            if (used.size() != 0 && $urandom_range(0, 1) == 1)
                a = used[$urandom_range(0, used.size() - 1)];
            else
                a = rand_addr();
            access(a, 0);
        end
        repeat (5) @(negedge clk);
        chk("refill_q_empty", refill_q.size(), 0);
        chk("beat_q_empty", beat_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
